// File: rtl/mmio_arb_pkg.sv
// Shared types and bus widths for the FPro MMIO bus arbiter.
package mmio_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUS, RESP} arb_state_t;

  localparam int MMIO_ADDR_W = 21;
  localparam int MMIO_DATA_W = 32;

endpackage

// File: rtl/rr_grant_picker.sv
// Combinational one-hot grant from the request vector and round-robin pointer.
// With MMIO_ARB_FIXED_PRIO_EN defined it reduces to a lowest-index priority encoder.
module rr_grant_picker #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt
);

`ifdef MMIO_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end
`else
  // Scan from the pointer upward, wrapping; first asserted request wins.
  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Serializes N_REQ requesters onto the single FPro MMIO bus with a one-cycle ack.
// Define MMIO_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
//
// state | meaning
// IDLE  | waiting for a request; grant and latch winner's transaction
// BUS   | strobes asserted for one cycle; read data captured at closing edge
// RESP  | one-cycle ack to the latched requester; advance rr pointer
module mmio_bus_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = MMIO_ADDR_W,
  parameter int DATA_W = MMIO_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_wr,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wr_data,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       ack_rd_data,
  output logic                    arb_busy,
  output logic                    mmio_cs,
  output logic                    mmio_wr,
  output logic                    mmio_rd,
  output logic [ADDR_W-1:0]       mmio_addr,
  output logic [DATA_W-1:0]       mmio_wr_data,
  input  logic [DATA_W-1:0]       mmio_rd_data
);

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_t        state_q, state_d;
  logic              load;
  logic [N_REQ-1:0]  gnt;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  id_q;
  logic              wr_q;
  logic [PTR_W-1:0]  win_id;
  logic              win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  rr_grant_picker #(
    .N_REQ(N_REQ),
    .PTR_W(PTR_W)
  ) u_picker (
    .req(req),
    .ptr(ptr),
    .gnt(gnt)
  );

  always_comb begin
    win_id   = '0;
    win_wr   = 1'b0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        win_id   = PTR_W'(i);
        win_wr   = req_wr[i];
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
        win_data = req_wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUS;
          load    = 1'b1;
        end
      end
      BUS:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mmio_addr/mmio_wr_data are the transaction registers themselves, so they
  // hold the last granted values outside BUS.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      id_q         <= '0;
      mmio_addr    <= '0;
      mmio_wr_data <= '0;
      ack_rd_data  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        wr_q         <= win_wr;
        id_q         <= win_id;
        mmio_addr    <= win_addr;
        mmio_wr_data <= win_data;
      end
      if (state_q == BUS && !wr_q) ack_rd_data <= mmio_rd_data;
    end
  end

`ifdef MMIO_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (state_q == RESP) begin
      ptr <= (int'(id_q) == N_REQ - 1) ? '0 : id_q + 1'b1;
    end
  end
`endif

  assign arb_busy = (state_q != IDLE);
  assign mmio_cs  = (state_q == BUS);
  assign mmio_wr  = mmio_cs & wr_q;
  assign mmio_rd  = mmio_cs & ~wr_q;

  always_comb begin
    ack = '0;
    if (state_q == RESP) ack[id_q] = 1'b1;
  end

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Self-checking bench for mmio_bus_arbiter: directed scenarios plus a randomized
// transaction-level reference model. Honours MMIO_ARB_FIXED_PRIO_EN when defined.
module tb_mmio_bus_arbiter;
  localparam int N  = 2;
  localparam int AW = 21;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req, req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wr_data;
  logic [N-1:0]  ack;
  logic [DW-1:0] ack_rd_data;
  logic          arb_busy, mmio_cs, mmio_wr, mmio_rd;
  logic [AW-1:0] mmio_addr;
  logic [DW-1:0] mmio_wr_data, mmio_rd_data;

  logic          t_req  [N];
  logic          t_wr   [N];
  logic [AW-1:0] t_addr [N];
  logic [DW-1:0] t_data [N];

  logic [DW-1:0] slot_mem [8];
  logic          slot_init;

  int checks;
  int errors;

  mmio_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .ack(ack), .ack_rd_data(ack_rd_data), .arb_busy(arb_busy),
    .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd), .mmio_addr(mmio_addr),
    .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    req = '0; req_wr = '0; req_addr = '0; req_wr_data = '0;
    for (int i = 0; i < N; i++) begin
      req[i] = t_req[i];
      req_wr[i] = t_wr[i];
      req_addr[i*AW +: AW] = t_addr[i];
      req_wr_data[i*DW +: DW] = t_data[i];
    end
  end

  // Slot model: eight words aliased on the low address bits, combinational read.
  assign mmio_rd_data = slot_mem[mmio_addr[2:0]];
  always @(posedge clk) begin
    if (slot_init) begin
      for (int k = 0; k < 8; k++) slot_mem[k] <= (k == 1) ? 32'hDEADBEEF : 32'h1000_0000 + k;
    end else if (mmio_cs && mmio_wr) begin
      slot_mem[mmio_addr[2:0]] <= mmio_wr_data;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic r, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
    t_req[i] = r; t_wr[i] = w; t_addr[i] = a; t_data[i] = d;
  endtask

  task automatic new_txn(int i);
    set_req(i, 1'b1, 1'($urandom_range(1, 0)), AW'($urandom), $urandom);
  endtask

  task automatic drop_all();
    for (int i = 0; i < N; i++) t_req[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drop_all();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({ack, arb_busy, mmio_cs, mmio_wr, mmio_rd} !== '0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0", {ack, arb_busy, mmio_cs, mmio_wr, mmio_rd});
    end
    checks++;
    if (mmio_addr !== '0 || mmio_wr_data !== '0) begin
      errors++; $display("FAIL reset_bus got addr=%h wd=%h exp 0 0", mmio_addr, mmio_wr_data);
    end
    checks++;
    if (ack_rd_data !== '0) begin
      errors++; $display("FAIL reset_rdata got=%h exp=0", ack_rd_data);
    end
    next_cycle();
  endtask

  task automatic test_read();
    do_reset();
    set_req(0, 1'b1, 1'b0, 21'h000C1, 32'h0);
    @(negedge clk);
    checks++;
    if ({mmio_cs, mmio_rd} !== 2'b00) begin
      errors++; $display("FAIL read_c0 got cs,rd=%b exp=00", {mmio_cs, mmio_rd});
    end
    next_cycle(); @(negedge clk);
    checks++;
    if ({mmio_cs, mmio_wr, mmio_rd} !== 3'b101 || mmio_addr !== 21'h000C1 || ack !== 2'b00) begin
      errors++; $display("FAIL read_c1 got cs,wr,rd=%b addr=%h ack=%b exp 101 000c1 00", {mmio_cs, mmio_wr, mmio_rd}, mmio_addr, ack);
    end
    next_cycle(); @(negedge clk);
    checks++;
    if (ack !== 2'b01 || ack_rd_data !== 32'hDEADBEEF || mmio_rd !== 1'b0) begin
      errors++; $display("FAIL read_c2 got ack=%b rd=%b data=%h exp 01 0 deadbeef", ack, mmio_rd, ack_rd_data);
    end
    next_cycle();
    set_req(0, 1'b0, 1'b0, 21'h000C1, 32'h0);
    @(negedge clk);
    checks++;
    if (ack !== 2'b00 || arb_busy !== 1'b0) begin
      errors++; $display("FAIL read_c3 got ack=%b busy=%b exp 00 0", ack, arb_busy);
    end
    next_cycle();
  endtask

  task automatic test_write();
    set_req(1, 1'b1, 1'b1, 21'h00080, 32'h5);
    @(negedge clk);
    next_cycle(); @(negedge clk);
    checks++;
    if ({mmio_cs, mmio_wr, mmio_rd} !== 3'b110 || mmio_addr !== 21'h00080 || mmio_wr_data !== 32'h5) begin
      errors++; $display("FAIL write_c1 got cs,wr,rd=%b addr=%h wd=%h exp 110 00080 5", {mmio_cs, mmio_wr, mmio_rd}, mmio_addr, mmio_wr_data);
    end
    next_cycle(); @(negedge clk);
    checks++;
    if (ack !== 2'b10 || ack_rd_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_c2 got ack=%b data=%h exp 10 deadbeef", ack, ack_rd_data);
    end
    next_cycle();
    set_req(1, 1'b0, 1'b1, 21'h00080, 32'h5);
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_alternate();
    logic [N-1:0] exp_ack;
    do_reset();
    set_req(0, 1'b1, 1'b0, 21'h000C1, 32'h0);
    set_req(1, 1'b1, 1'b0, 21'h00082, 32'h0);
    for (int c = 0; c < 18; c++) begin
      exp_ack = '0;
`ifdef MMIO_ARB_FIXED_PRIO_EN
      if (c % 3 == 2) exp_ack[0] = 1'b1;
`else
      if (c % 3 == 2) exp_ack[(c / 3) % 2] = 1'b1;
`endif
      @(negedge clk);
      checks++;
      if (ack !== exp_ack) begin
        errors++; $display("FAIL alternate cyc=%0d got ack=%b exp=%b", c, ack, exp_ack);
      end
      next_cycle();
    end
    drop_all();
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_ack;
    do_reset();
    set_req(1, 1'b1, 1'b0, 21'h00003, 32'h0);
    for (int c = 0; c < 9; c++) begin
      exp_ack = (c % 3 == 2) ? 2'b10 : 2'b00;
      @(negedge clk);
      checks++;
      if (ack !== exp_ack || mmio_cs !== (c % 3 == 1)) begin
        errors++; $display("FAIL back_to_back cyc=%0d got ack=%b cs=%b exp %b %b", c, ack, mmio_cs, exp_ack, (c % 3 == 1));
      end
      next_cycle();
    end
    drop_all();
    @(negedge clk);
    next_cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 1'b1, 1'b0, 21'h000C1, 32'h0);
    repeat (3) begin @(negedge clk); next_cycle(); end
    set_req(0, 1'b0, 1'b0, 21'h000C1, 32'h0);
    set_req(1, 1'b1, 1'b1, 21'h00003, 32'h77);
    @(negedge clk); next_cycle();
    @(negedge clk);
    checks++;
    if ({mmio_cs, mmio_wr} !== 2'b11) begin
      errors++; $display("FAIL midreset_bus got cs,wr=%b exp=11", {mmio_cs, mmio_wr});
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 21'h000C1, 32'h0);
    @(negedge clk);
    checks++;
    if ({ack, arb_busy, mmio_cs, mmio_wr, mmio_rd} !== '0) begin
      errors++; $display("FAIL midreset_after got ack,busy,cs,wr,rd=%b exp=0", {ack, arb_busy, mmio_cs, mmio_wr, mmio_rd});
    end
    next_cycle(); @(negedge clk);
    next_cycle(); @(negedge clk);
    checks++;
    if (ack !== 2'b01) begin
      errors++; $display("FAIL midreset_ptr got ack=%b exp=01", ack);
    end
    next_cycle();
    drop_all();
    @(negedge clk);
    next_cycle();
  endtask

  // Transaction-level model: the arbiter is free every third cycle after a grant;
  // a grant at cycle n strobes the bus at n+1 and acks at n+2.
  task automatic test_random();
    localparam int NCYC = 400;
    int ptr, nfree, bus_c, ack_c, gid, w;
    logic gwr, quiet, exp_cs;
    logic [AW-1:0] gaddr, exp_addr;
    logic [DW-1:0] gdata, exp_wd, exp_rd;
    logic [DW-1:0] shadow [8];
    logic [N-1:0] exp_ack;
    do_reset();
    for (int k = 0; k < 8; k++) shadow[k] = slot_mem[k];
    ptr = 0; nfree = 0; bus_c = -10; ack_c = -10; gid = 0; gwr = 1'b0;
    gaddr = '0; gdata = '0; exp_addr = '0; exp_wd = '0; exp_rd = '0;
    for (int n = 0; n < NCYC; n++) begin
      quiet = (n >= NCYC - 6);
      for (int i = 0; i < N; i++) begin
        if (n - 1 == ack_c && gid == i) begin
          if (!quiet && $urandom_range(1, 0) == 1) new_txn(i);
          else t_req[i] = 1'b0;
        end else if (!t_req[i]) begin
          if (!quiet && $urandom_range(3, 0) == 0) new_txn(i);
        end else if (!(gid == i && n <= ack_c) && (quiet || $urandom_range(7, 0) == 0)) begin
          t_req[i] = 1'b0;
        end
      end
      if (n >= nfree) begin
        w = -1;
`ifdef MMIO_ARB_FIXED_PRIO_EN
        for (int k = N - 1; k >= 0; k--) if (t_req[k]) w = k;
`else
        for (int k = N - 1; k >= 0; k--) if (t_req[(ptr + k) % N]) w = (ptr + k) % N;
`endif
        if (w >= 0) begin
          gid = w; gwr = t_wr[w]; gaddr = t_addr[w]; gdata = t_data[w];
          bus_c = n + 1; ack_c = n + 2; nfree = n + 3; ptr = (w + 1) % N;
        end
      end
      if (n == bus_c) begin exp_addr = gaddr; exp_wd = gdata; end
      exp_cs = (n == bus_c);
      exp_ack = '0;
      if (n == ack_c) exp_ack[gid] = 1'b1;
      @(negedge clk);
      checks++;
      if ({mmio_cs, mmio_wr, mmio_rd, arb_busy, ack} !==
          {exp_cs, exp_cs & gwr, exp_cs & ~gwr, (n == bus_c) || (n == ack_c), exp_ack}) begin
        errors++; $display("FAIL rand_ctrl cyc=%0d got cs,wr,rd,busy,ack=%b exp=%b", n,
          {mmio_cs, mmio_wr, mmio_rd, arb_busy, ack}, {exp_cs, exp_cs & gwr, exp_cs & ~gwr, (n == bus_c) || (n == ack_c), exp_ack});
      end
      checks++;
      if (mmio_addr !== exp_addr || mmio_wr_data !== exp_wd) begin
        errors++; $display("FAIL rand_bus cyc=%0d got addr=%h wd=%h exp %h %h", n, mmio_addr, mmio_wr_data, exp_addr, exp_wd);
      end
      checks++;
      if (ack_rd_data !== exp_rd) begin
        errors++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", n, ack_rd_data, exp_rd);
      end
      if (n == bus_c) begin
        if (gwr) shadow[gaddr[2:0]] = gdata;
        else     exp_rd = shadow[gaddr[2:0]];
      end
      next_cycle();
    end
    drop_all();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, '0, '0);
    slot_init = 1'b1;
    do_reset();
    slot_init = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_alternate();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
